// File: rtl/rvb_pcpi_issue_pkg.sv
// Shared types and defaults for the PCPI issue block and its protocol checker.
package rvb_pcpi_issue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } issue_state_e;

  typedef logic [31:0] pcpi_word_t;

  localparam int unsigned TimeoutCyclesDefault = 16;

endpackage

// File: rtl/rvb_pcpi_proto_chk.sv
// PCPI protocol checker: raises a sticky error flag the cycle after the responder
// breaks the valid/wait/ready/wr handshake rules.
module rvb_pcpi_proto_chk (
  input  logic clk,
  input  logic resetn,
  input  logic pcpi_valid,
  input  logic pcpi_wr,
  input  logic pcpi_wait,
  input  logic pcpi_ready,
  output logic proto_err
);

  logic prev_valid_q;
  logic err_q;
  logic violation;

  // The responder may stay silent only in the first cycle of a request.
  always_comb begin
    violation = 1'b0;
    if (pcpi_valid) begin
      if (pcpi_ready != pcpi_wr) violation = 1'b1;
      if (prev_valid_q && !pcpi_wait && !pcpi_ready) violation = 1'b1;
    end else if (pcpi_wait || pcpi_ready || pcpi_wr) begin
      violation = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_valid_q <= pcpi_valid;
      err_q        <= err_q | violation;
    end
  end

  assign proto_err = err_q;

endmodule

// File: rtl/rvb_pcpi_issue.sv
// PCPI initiator: issues one command to a PCPI coprocessor and returns its result.
// Define RVB_PCPI_ISSUE_CHECK_EN to build in the protocol checker driving proto_err.
module rvb_pcpi_issue
  import rvb_pcpi_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault,
  parameter int unsigned LAT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  input  logic [31:0]      cmd_rs3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rd,
  output logic             rsp_wr,
  output logic             rsp_illegal,
  output logic [LAT_W-1:0] rsp_cycles,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  output logic [31:0]      pcpi_rs3,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready,
  output logic             proto_err
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  issue_state_e state_q, state_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  pcpi_word_t       insn_q, insn_d;
  pcpi_word_t       rs1_q, rs1_d;
  pcpi_word_t       rs2_q, rs2_d;
  pcpi_word_t       rs3_q, rs3_d;
  logic             rsp_valid_q, rsp_valid_d;
  pcpi_word_t       rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             illegal_q, illegal_d;
  logic [LAT_W-1:0] cycles_q, cycles_d;
  logic [7:0]       to_q, to_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic             accept;
  logic [7:0]       to_inc;
  logic             expire;
  logic [LAT_W-1:0] lat_inc;

  assign accept  = (state_q == StIdle) && cmd_ready_q && cmd_valid;
  assign to_inc  = to_q + 8'd1;
  // Only a run of non-wait cycles can time out; a wait cycle restarts the run.
  assign expire  = !pcpi_wait && (to_inc == TimeoutVal);
  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready response beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (pcpi_ready || expire) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rs3_d     = rs3_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    cycles_d  = cycles_q;
    to_d      = to_q;
    lat_d     = lat_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          insn_d = cmd_insn;
          rs1_d  = cmd_rs1;
          rs2_d  = cmd_rs2;
          rs3_d  = cmd_rs3;
          to_d   = 8'd0;
          lat_d  = '0;
        end
      end
      StIssue: begin
        lat_d = lat_inc;
        to_d  = pcpi_wait ? 8'd0 : to_inc;
        if (pcpi_ready) begin
          rd_d      = pcpi_rd;
          wr_d      = pcpi_wr;
          illegal_d = 1'b0;
          cycles_d  = lat_inc;
        end else if (expire) begin
          rd_d      = '0;
          wr_d      = 1'b0;
          illegal_d = 1'b1;
          cycles_d  = lat_inc;
        end
      end
      default: ;
    endcase

    cmd_ready_d  = (state_d == StIdle);
    pcpi_valid_d = (state_d == StIssue);
    rsp_valid_d  = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_ready_q  <= 1'b0;
      pcpi_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rd_q         <= '0;
      wr_q         <= 1'b0;
      illegal_q    <= 1'b0;
      cycles_q     <= '0;
      to_q         <= 8'd0;
      lat_q        <= '0;
    end else begin
      cmd_ready_q  <= cmd_ready_d;
      pcpi_valid_q <= pcpi_valid_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs3_q        <= rs3_d;
      rsp_valid_q  <= rsp_valid_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      illegal_q    <= illegal_d;
      cycles_q     <= cycles_d;
      to_q         <= to_d;
      lat_q        <= lat_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign pcpi_valid  = pcpi_valid_q;
  assign pcpi_insn   = insn_q;
  assign pcpi_rs1    = rs1_q;
  assign pcpi_rs2    = rs2_q;
  assign pcpi_rs3    = rs3_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rd_q;
  assign rsp_wr      = wr_q;
  assign rsp_illegal = illegal_q;
  assign rsp_cycles  = cycles_q;

`ifdef RVB_PCPI_ISSUE_CHECK_EN
  rvb_pcpi_proto_chk u_proto_chk (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid_q),
    .pcpi_wr    (pcpi_wr),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .proto_err  (proto_err)
  );
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvb_pcpi_issue.sv
// Self-checking bench for rvb_pcpi_issue: scripted/random PCPI responder checked
// against a cycle-count reference model of the issue rules.
module tb_rvb_pcpi_issue;

  localparam int Timeout = 16;
  localparam int LatMax  = 255;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2, cmd_rs3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic        rsp_illegal;
  logic [7:0]  rsp_cycles;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        proto_err;

  always #5 clk = ~clk;

  rvb_pcpi_issue #(
    .TIMEOUT_CYCLES (Timeout),
    .LAT_W          (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_insn    (cmd_insn),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rs3     (cmd_rs3),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd      (rsp_rd),
    .rsp_wr      (rsp_wr),
    .rsp_illegal (rsp_illegal),
    .rsp_cycles  (rsp_cycles),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_rs3    (pcpi_rs3),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .proto_err   (proto_err)
  );

  int total = 0;
  int bad   = 0;

  // Responder script: wait_v[k] is pcpi_wait in valid cycle k; ready_at is the ready cycle (0 = never).
  bit          wait_v [400];
  int          ready_at;
  logic [31:0] rd_val;
  int          exp_cycles;
  bit          exp_illegal;
  bit          exp_viol;
  bit          err_exp;
  logic [31:0] insn, rs1, rs2, rs3;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Walks the valid cycles: ready ends it, otherwise a run of Timeout non-wait cycles does.
  function automatic void ref_model();
    int run = 0;
    exp_cycles  = 0;
    exp_illegal = 0;
    exp_viol    = 0;
    for (int k = 1; k < 400; k++) begin
      if (k >= 2 && !wait_v[k] && ready_at != k) exp_viol = 1;
      if (ready_at == k) begin
        exp_cycles = k;
        return;
      end
      run = wait_v[k] ? 0 : run + 1;
      if (run == Timeout) begin
        exp_cycles  = k;
        exp_illegal = 1;
        return;
      end
    end
  endfunction

  task automatic clear_script();
    for (int i = 0; i < 400; i++) wait_v[i] = 0;
    ready_at = 0;
    rd_val   = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_val({tag, "_rsp_rd"}, rsp_rd, 0);
    check_val({tag, "_rsp_wr"}, 32'(rsp_wr), 0);
    check_val({tag, "_rsp_illegal"}, 32'(rsp_illegal), 0);
    check_val({tag, "_rsp_cycles"}, 32'(rsp_cycles), 0);
    check_val({tag, "_pcpi_valid"}, 32'(pcpi_valid), 0);
    check_val({tag, "_pcpi_insn"}, pcpi_insn, 0);
    check_val({tag, "_pcpi_rs1"}, pcpi_rs1, 0);
    check_val({tag, "_pcpi_rs2"}, pcpi_rs2, 0);
    check_val({tag, "_pcpi_rs3"}, pcpi_rs3, 0);
    check_val({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_ready_wait", 32'(cmd_ready), 1);
  endtask

  // Runs one command with the current script; called at a negedge with responder idle.
  task automatic run_txn(input int delay);
    logic [31:0] exp_rd;
    int          exp_cyc;
    wait_cmd_ready();
    insn = $urandom; rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
    cmd_valid = 1'b1;
    cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rs3 = rs3;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom; cmd_rs3 = $urandom;
    ref_model();
`ifdef RVB_PCPI_ISSUE_CHECK_EN
    if (exp_viol) err_exp = 1;
`endif
    for (int k = 1; k <= exp_cycles; k++) begin
      check_val("pcpi_valid_hi", 32'(pcpi_valid), 1);
      check_val("pcpi_insn", pcpi_insn, insn);
      check_val("pcpi_rs1", pcpi_rs1, rs1);
      check_val("pcpi_rs2", pcpi_rs2, rs2);
      check_val("pcpi_rs3", pcpi_rs3, rs3);
      check_val("rsp_valid_busy", 32'(rsp_valid), 0);
      pcpi_wait  = wait_v[k];
      pcpi_ready = (k == ready_at);
      pcpi_wr    = (k == ready_at);
      pcpi_rd    = (k == ready_at) ? rd_val : $urandom;
      @(negedge clk);
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'h0;
    exp_rd  = exp_illegal ? 32'h0 : rd_val;
    exp_cyc = (exp_cycles > LatMax) ? LatMax : exp_cycles;
    for (int d = 0; d <= delay; d++) begin
      check_val("rsp_valid", 32'(rsp_valid), 1);
      check_val("pcpi_valid_resp", 32'(pcpi_valid), 0);
      check_val("cmd_ready_resp", 32'(cmd_ready), 0);
      check_val("rsp_rd", rsp_rd, exp_rd);
      check_val("rsp_wr", 32'(rsp_wr), 32'(!exp_illegal));
      check_val("rsp_illegal", 32'(rsp_illegal), 32'(exp_illegal));
      check_val("rsp_cycles", 32'(rsp_cycles), 32'(exp_cyc));
      check_val("proto_err", 32'(proto_err), 32'(err_exp));
      if (d == delay) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_val("rsp_valid_done", 32'(rsp_valid), 0);
    check_val("cmd_ready_done", 32'(cmd_ready), 1);
    check_val("pcpi_valid_done", 32'(pcpi_valid), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    err_exp = 0;
    check_all_zero("reset");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int mode;
    resetn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rs3 = '0;
    pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
    err_exp = 0;
    repeat (2) @(negedge clk);
    check_all_zero("init");
    resetn = 1'b1;
    @(negedge clk);

    // Simple op
    clear_script(); wait_v[1] = 1; ready_at = 2; rd_val = 32'h12345678;
    run_txn(0);
    // Long op
    clear_script(); for (int i = 1; i <= 6; i++) wait_v[i] = 1; ready_at = 7;
    run_txn(1);
    // Timeout
    clear_script();
    run_txn(0);
    // Wait cycle restarts the timeout run
    clear_script(); wait_v[11] = 1;
    run_txn(0);
    // Ready coincident with timeout expiry
    clear_script(); ready_at = Timeout;
    run_txn(0);
    // Response backpressure
    clear_script(); wait_v[1] = 1; ready_at = 2;
    run_txn(5);
    // Latency saturation
    clear_script(); for (int i = 1; i <= 300; i++) wait_v[i] = 1; ready_at = 300;
    run_txn(0);

    for (int t = 0; t < 30; t++) begin
      clear_script();
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        ready_at = int'($urandom_range(1, 30));
        for (int i = 1; i <= 30; i++) wait_v[i] = 1'($urandom);
      end else if (mode == 1) begin
        for (int i = 1; i <= 60; i++) wait_v[i] = ($urandom_range(0, 3) == 0);
      end else begin
        ready_at = int'($urandom_range(1, 60));
        for (int i = 1; i <= ready_at; i++) wait_v[i] = 1;
      end
      run_txn(int'($urandom_range(0, 3)));
    end

    // Reset mid-ISSUE
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_insn = $urandom; cmd_rs1 = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0; pcpi_wait = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_pcpi_valid", 32'(pcpi_valid), 1);
    pcpi_wait = 1'b0;
    do_reset();
    @(negedge clk);
    check_val("post_reset_cmd_ready", 32'(cmd_ready), 1);

    // Stray ready while idle
    pcpi_ready = 1'b1;
    @(negedge clk);
    pcpi_ready = 1'b0;
`ifdef RVB_PCPI_ISSUE_CHECK_EN
    err_exp = 1;
`endif
    @(negedge clk);
    check_val("stray_proto_err", 32'(proto_err), 32'(err_exp));
    repeat (3) @(negedge clk);
    check_val("sticky_proto_err", 32'(proto_err), 32'(err_exp));
    do_reset();

    clear_script(); wait_v[1] = 1; ready_at = 3;
    run_txn(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
